// File: rtl/sram_pkg.sv
// Shared types for the SRAM page tracker.
package sram_pkg;

   localparam int DEF_NUM_PORTS = 16;
   localparam int DEF_PAGE_NUM  = 2048;
   localparam int DEF_ECC_WIDTH = 8;

   typedef logic [$clog2(DEF_PAGE_NUM)-1:0]  page_addr_t;
   typedef logic [$clog2(DEF_NUM_PORTS)-1:0] port_id_t;
   typedef logic [$clog2(DEF_PAGE_NUM):0]    page_cnt_t;
   typedef logic [DEF_ECC_WIDTH-1:0]         ecc_t;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } tracker_state_e;

endpackage

// File: rtl/page_free_fifo.sv
// First-word-fall-through free-page FIFO; occupancy is tracked by the owner.
module page_free_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    head_q;
   logic [AW-1:0]    tail_q;

   always_ff @(posedge clk) begin
      if (push_i) mem_q[tail_q] <= push_data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         if (push_i) tail_q <= tail_q + 1'b1;
         if (pop_i)  head_q <= head_q + 1'b1;
      end
   end

   assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/sram_page_tracker.sv
// Per-bank page bookkeeping: ECC store, port counts, self-initialising free list.
// Define SRAM_PAGE_TRACKER_ERR_EN to add sticky err_alloc/err_free flags.
module sram_page_tracker
   import sram_pkg::*;
#(
   parameter  int NUM_PORTS = DEF_NUM_PORTS,
   parameter  int PAGE_NUM  = DEF_PAGE_NUM,
   parameter  int ECC_WIDTH = DEF_ECC_WIDTH,
   localparam int PW        = $clog2(NUM_PORTS),
   localparam int AW        = $clog2(PAGE_NUM)
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 init_done,
   input  logic                 ecc_wr_en,
   input  logic [AW-1:0]        ecc_wr_addr,
   input  logic [ECC_WIDTH-1:0] ecc_din,
   input  logic                 ecc_rd_en,
   input  logic [AW-1:0]        ecc_rd_addr,
   output logic [ECC_WIDTH-1:0] ecc_dout,
   input  logic                 alloc_req,
   input  logic [PW-1:0]        alloc_port,
   output logic [AW-1:0]        alloc_ptr,
   output logic                 alloc_ok,
   input  logic                 free_req,
   input  logic [PW-1:0]        free_port,
   input  logic [AW-1:0]        free_addr,
   input  logic [PW-1:0]        query_port,
   output logic [AW:0]          query_amount,
`ifdef SRAM_PAGE_TRACKER_ERR_EN
   output logic                 err_alloc,
   output logic                 err_free,
`endif
   output logic [AW:0]          free_space
);

   localparam logic [AW:0] PAGES = (AW+1)'(PAGE_NUM);
   localparam logic [AW:0] LAST  = (AW+1)'(PAGE_NUM - 1);

   tracker_state_e       state_q;
   logic                 init_done_q;
   logic [AW:0]          free_space_q, free_space_d;
   logic [AW:0]          cnt_q [NUM_PORTS];
   logic [ECC_WIDTH-1:0] ecc_mem_q [PAGE_NUM];
   logic [ECC_WIDTH-1:0] ecc_dout_q;

   logic          in_init, in_run;
   logic          alloc_fire, free_fire;
   logic          fifo_push;
   logic [AW-1:0] fifo_data;

   assign in_init    = (state_q == ST_INIT);
   assign in_run     = (state_q == ST_RUN);
   assign alloc_ok   = init_done_q && (free_space_q != '0);
   assign alloc_fire = alloc_req && alloc_ok;
   assign free_fire  = free_req && in_run && (free_space_q < PAGES)
                       && (cnt_q[free_port] != '0);

   // During init the free-space count doubles as the page index being pushed.
   assign fifo_push = in_init || free_fire;
   assign fifo_data = in_init ? free_space_q[AW-1:0] : free_addr;

   always_comb begin
      free_space_d = free_space_q;
      if (in_init)
         free_space_d = free_space_q + 1'b1;
      else if (alloc_fire && !free_fire)
         free_space_d = free_space_q - 1'b1;
      else if (free_fire && !alloc_fire)
         free_space_d = free_space_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         init_done_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_INIT: if (free_space_q == LAST) begin
               state_q     <= ST_RUN;
               init_done_q <= 1'b1;
            end
            ST_RUN: state_q <= ST_RUN;
            default: state_q <= ST_INIT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         free_space_q <= '0;
         for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
      end else begin
         free_space_q <= free_space_d;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (alloc_fire && alloc_port == PW'(p)
                && !(free_fire && free_port == PW'(p)))
               cnt_q[p] <= cnt_q[p] + 1'b1;
            else if (free_fire && free_port == PW'(p)
                     && !(alloc_fire && alloc_port == PW'(p)))
               cnt_q[p] <= cnt_q[p] - 1'b1;
         end
      end
   end

   page_free_fifo #(
      .DEPTH (PAGE_NUM),
      .WIDTH (AW)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifo_push),
      .push_data_i (fifo_data),
      .pop_i       (alloc_fire),
      .head_data_o (alloc_ptr)
   );

   always_ff @(posedge clk) begin
      if (ecc_wr_en) ecc_mem_q[ecc_wr_addr] <= ecc_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            ecc_dout_q <= '0;
      else if (ecc_rd_en) ecc_dout_q <= ecc_mem_q[ecc_rd_addr];
   end

`ifdef SRAM_PAGE_TRACKER_ERR_EN
   logic err_alloc_q, err_free_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_alloc_q <= 1'b0;
         err_free_q  <= 1'b0;
      end else begin
         if (alloc_req && in_run && free_space_q == '0) err_alloc_q <= 1'b1;
         if (free_req && in_run && !free_fire)          err_free_q  <= 1'b1;
      end
   end

   assign err_alloc = err_alloc_q;
   assign err_free  = err_free_q;
`endif

   assign init_done    = init_done_q;
   assign ecc_dout     = ecc_dout_q;
   assign free_space   = free_space_q;
   assign query_amount = cnt_q[query_port];

endmodule

// File: doc/sram_page_tracker.md
Name: sram_page_tracker

Overview:
- Parametrised next-generation SRAM bookkeeping block for one shared packet SRAM.
- Holds per-page ECC codes, per-port page counts, the free-space count, and an integrated free-page FIFO.
- Adds a self-initialising free list, alloc/free legality checking, and generic port/page counts.
- Sits beside each SRAM bank, between the write-side page allocator and the read-side page releaser.

Parameters:
- NUM_PORTS, 16, number of ports tracked; PW = $clog2(NUM_PORTS) is derived.
- PAGE_NUM, 2048, number of SRAM pages; must be a power of two; AW = $clog2(PAGE_NUM) is derived.
- ECC_WIDTH, 8, width of each ECC code word.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- init_done  out  1  high once the free list is fully populated.
- ecc_wr_en  in  1  ECC storage write enable.
- ecc_wr_addr  in  AW  ECC write address.
- ecc_din  in  ECC_WIDTH  ECC write data.
- ecc_rd_en  in  1  ECC storage read enable.
- ecc_rd_addr  in  AW  ECC read address.
- ecc_dout  out  ECC_WIDTH  registered ECC read data.
- alloc_req  in  1  pop one free page for alloc_port.
- alloc_port  in  PW  port charged with the allocated page.
- alloc_ptr  out  AW  current free-list head; combinational, first-word-fall-through.
- alloc_ok  out  1  combinational: init_done && free_space != 0.
- free_req  in  1  return free_addr to the free list.
- free_port  in  PW  port credited for the freed page.
- free_addr  in  AW  page being released.
- query_port  in  PW  port selector for query_amount.
- query_amount  out  AW+1  combinational page count of query_port.
- free_space  out  AW+1  number of free pages.
- err_alloc  out  1  sticky illegal-allocation flag; present only when the optional feature is compiled in.
- err_free  out  1  sticky illegal-free flag; present only when the optional feature is compiled in.

Behaviour:
- Reset values: FSM=INIT, free_space=0, all port counters=0, FIFO head/tail=0, ecc_dout=0, init_done=0, err_*=0. The ECC array and FIFO array are not cleared.
- FSM INIT: one cycle per page, push page index i (0..PAGE_NUM-1) into the FIFO tail and increment free_space. After PAGE_NUM cycles go to RUN; init_done=1 from the next cycle. Init therefore takes exactly PAGE_NUM cycles after reset release.
- While in INIT: alloc_req and free_req are ignored and not flagged; alloc_ok=0.
- FSM RUN: no exit except reset.
- ECC storage is usable in both states and unaffected by FSM state.
  - Write: commits at the edge.
  - Read: 1-cycle latency; ecc_dout holds its value when ecc_rd_en=0.
  - Same-address read and write in one cycle: read returns the old data.
- Legal alloc = alloc_req && alloc_ok.
  - alloc_ptr is consumed in the same cycle and the head advances.
  - The next head is visible the following cycle.
  - free_space decrements by 1; port_cnt[alloc_port] increments by 1.
- Legal free = free_req && RUN && free_space < PAGE_NUM && port_cnt[free_port] != 0.
  - free_addr is pushed at the tail.
  - free_space increments by 1; port_cnt[free_port] decrements by 1.
- Illegal requests are dropped entirely: no push, no pop, no counter change.
- Simultaneous legal alloc and free:
  - free_space is unchanged.
  - If the ports differ, both counters update; if they are equal, the counter is unchanged.
  - The FIFO pops and pushes in the same cycle.
  - A free page pushed when free_space=0 is visible at alloc_ptr the next cycle, never the same cycle.
- Head/tail pointers are AW bits wide and wrap modulo PAGE_NUM.
- Counters are AW+1 bits wide. Saturation cannot occur under legal traffic, because the legality checks block it.
- free_addr is not checked against double-free; that is the caller's responsibility.
- Reset mid-operation: asynchronous clear of all state listed above, FSM re-enters INIT, and the free list is rebuilt from scratch.

Optional Feature:
- Macro: SRAM_PAGE_TRACKER_ERR_EN.
- With the macro:
  - err_alloc sets on alloc_req && RUN && free_space==0.
  - err_free sets on any illegal free in RUN.
  - Both flags are sticky until rst.
- Without the macro: both ports and their logic are absent; illegal requests are still silently dropped.

Decomposition:
- Shared package sram_pkg:
  - typedef page_addr_t (AW bits), port_id_t (PW bits), page_cnt_t (AW+1 bits), ecc_t;
  - FSM enum tracker_state_e {ST_INIT, ST_RUN};
  - default constants for NUM_PORTS and PAGE_NUM.
- Sub-module page_free_fifo (parametrised on depth and width):
  - first-word-fall-through;
  - push/pop with head/tail wrap.
  - The tracker owns all counting and legality.

Test Plan:
- PAGE_NUM=16, release rst → init_done rises after 16 cycles, free_space=16, alloc_ptr=0, alloc_ok=1.
- Alloc port 3 four consecutive cycles → alloc_ptr sequence 0,1,2,3; query_amount(3)=4; free_space=12.
- Alloc port 2 and free page 1 from port 3 in the same cycle → free_space unchanged at 12, port 2 count=1, port 3 count=3.
- Drain all 16 pages, then free page 9 with alloc_req high → alloc rejected that cycle (err_alloc=1 with macro); next cycle alloc_ptr=9, alloc_ok=1.
- Free from a port whose count is 0 → no change to any counter or the FIFO; err_free=1 with macro, no flag without it.
- ECC write 0xA5 to address 7 while reading address 7 → dout holds the old value; next read of address 7 returns 0xA5.
- Assert rst mid-RUN → counters 0 immediately, init_done=0, re-init for 16 cycles, alloc_ptr=0.
